// File: rtl/food_spawner_pkg.sv
// Shared constants for the food spawner: game states, spawner FSM encoding
// and the 16-bit Galois LFSR step (taps 16,14,13,11).
package food_pkg;

   localparam logic [1:0] GS_MENU  = 2'b00;
   localparam logic [1:0] GS_PLAY  = 2'b01;
   localparam logic [1:0] GS_PAUSE = 2'b10;
   localparam logic [1:0] GS_OVER  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAW,
      S_QUERY,
      S_COMMIT
   } state_t;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/food_spawner_if.sv
// Occupancy-query handshake between the food spawner (master) and the
// snake body tracker (slave).
interface food_spawner_if #(
   parameter int X_W = 5,
   parameter int Y_W = 5
);
   logic           occ_req;
   logic [X_W-1:0] occ_x;
   logic [Y_W-1:0] occ_y;
   logic           occ_ack;
   logic           occ_hit;

   modport master (output occ_req, occ_x, occ_y, input occ_ack, occ_hit);
   modport slave  (input occ_req, occ_x, occ_y, output occ_ack, occ_hit);
endinterface

// File: rtl/food_spawner_lfsr16.sv
// Free-running 16-bit Galois LFSR; holds SEED while reset is asserted.
module lfsr16
   import food_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge value, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) q <= SEED;
      else     q <= lfsr_next(q);
   end

endmodule

// File: rtl/food_spawner.sv
// Food spawner: keeps N_FOOD food slots placed on free, distinct grid cells
// using LFSR rejection sampling plus an occupancy query to the snake tracker.
module food_spawner
   import food_pkg::*;
#(
   parameter int          GRID_W    = 32,
   parameter int          GRID_H    = 24,
   parameter int          N_FOOD    = 2,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          MAX_TRIES = 15,
   localparam int         X_W       = $clog2(GRID_W),
   localparam int         Y_W       = $clog2(GRID_H),
   localparam int         I_W       = (N_FOOD > 1) ? $clog2(N_FOOD) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            game_state,
   input  logic                  get_food,
   input  logic [I_W-1:0]        eaten_idx,
   food_spawner_if.master        occ,
   output logic [N_FOOD*X_W-1:0] food_x,
   output logic [N_FOOD*Y_W-1:0] food_y,
   output logic [N_FOOD-1:0]     food_valid,
   output logic                  busy,
   output logic                  spawn_fail
);

   localparam int T_W = $clog2(MAX_TRIES + 1);

   state_t            state;
   logic [1:0]        gs_q;
   logic [N_FOOD-1:0] pending;
   logic [X_W-1:0]    fx [N_FOOD];
   logic [Y_W-1:0]    fy [N_FOOD];
   logic [I_W-1:0]    cur_idx;
   logic [X_W-1:0]    cand_x;
   logic [Y_W-1:0]    cand_y;
   logic [T_W-1:0]    try_cnt;
   logic [15:0]       lfsr;
   logic              lfsr_unused;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr)
   );

   assign lfsr_unused = ^lfsr;

   logic           play;
   logic           start;
   logic           eat_ok;
   logic [X_W-1:0] draw_x;
   logic [Y_W-1:0] draw_y;
   logic           draw_ok;
   logic           reject;
   logic [I_W-1:0] next_idx;

   assign play   = (game_state == GS_PLAY);
   assign start  = play && ((gs_q == GS_MENU) || (gs_q == GS_OVER));
   assign eat_ok = play && get_food && (int'(eaten_idx) < N_FOOD) && food_valid[eaten_idx];
   assign draw_x = lfsr[X_W-1:0];
   assign draw_y = lfsr[8 +: Y_W];

   // NOTE: every always_comb output gets a default before any conditional
   // update, otherwise synthesis infers a latch for the untaken paths.
   always_comb begin
      draw_ok = (int'(draw_x) < GRID_W) && (int'(draw_y) < GRID_H);
      for (int i = 0; i < N_FOOD; i++) begin
         if (food_valid[i] && (fx[i] == draw_x) && (fy[i] == draw_y)) draw_ok = 1'b0;
      end
   end

   always_comb begin
      next_idx = '0;
      for (int i = N_FOOD - 1; i >= 0; i--) begin
         if (pending[i]) next_idx = I_W'(i);
      end
   end

   assign reject = ((state == S_DRAW) && !draw_ok) ||
                   ((state == S_QUERY) && occ.occ_ack && occ.occ_hit);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         gs_q        <= GS_MENU;
         pending     <= '0;
         food_valid  <= '0;
         cur_idx     <= '0;
         cand_x      <= '0;
         cand_y      <= '0;
         try_cnt     <= '0;
         spawn_fail  <= 1'b0;
         occ.occ_req <= 1'b0;
         occ.occ_x   <= '0;
         occ.occ_y   <= '0;
         // NOTE: the slot position array is reset because it drives
         // food_x/food_y directly and those must read 0 out of reset.
         for (int i = 0; i < N_FOOD; i++) begin
            fx[i] <= '0;
            fy[i] <= '0;
         end
      end else begin
         gs_q       <= game_state;
         spawn_fail <= 1'b0;

         if (!play) begin
            state       <= S_IDLE;
            occ.occ_req <= 1'b0;
            occ.occ_x   <= '0;
            occ.occ_y   <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if ((pending != '0) && !start) begin
                     state   <= S_DRAW;
                     cur_idx <= next_idx;
                  end
               end
               S_DRAW: begin
                  if (draw_ok) begin
                     state       <= S_QUERY;
                     cand_x      <= draw_x;
                     cand_y      <= draw_y;
                     occ.occ_req <= 1'b1;
                     occ.occ_x   <= draw_x;
                     occ.occ_y   <= draw_y;
                  end
               end
               S_QUERY: begin
                  if (occ.occ_ack) begin
                     occ.occ_req <= 1'b0;
                     occ.occ_x   <= '0;
                     occ.occ_y   <= '0;
                     state       <= occ.occ_hit ? S_DRAW : S_COMMIT;
                  end
               end
               S_COMMIT: begin
                  fx[cur_idx]         <= cand_x;
                  fy[cur_idx]         <= cand_y;
                  food_valid[cur_idx] <= 1'b1;
                  pending[cur_idx]    <= 1'b0;
                  state               <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase

            if (state == S_COMMIT) begin
               try_cnt <= '0;
            end else if (reject) begin
               if (try_cnt == T_W'(MAX_TRIES - 1)) begin
                  try_cnt    <= '0;
                  spawn_fail <= 1'b1;
               end else begin
                  try_cnt <= try_cnt + T_W'(1);
               end
            end
         end

         if (eat_ok) begin
            food_valid[eaten_idx] <= 1'b0;
            pending[eaten_idx]    <= 1'b1;
         end

         // A game start wins over any commit landing in the same cycle.
         if (start) begin
            food_valid <= '0;
            pending    <= '1;
         end
      end
   end

   for (genvar g = 0; g < N_FOOD; g++) begin : g_flat
      assign food_x[g*X_W +: X_W] = fx[g];
      assign food_y[g*Y_W +: Y_W] = fy[g];
   end

   assign busy = (state != S_IDLE) || (pending != '0);

endmodule
